// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 BCM scan engine.
package hub75_pkg;

    // Scan FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH,
        ST_DISPLAY,
        ST_NEXT
    } state_e;

    // Channel order inside a frame-buffer word, MSB first: {R0,G0,B0,R1,G1,B1}
    localparam int unsigned NUM_CH = 6;
    localparam int unsigned CH_R0  = 0;
    localparam int unsigned CH_G0  = 1;
    localparam int unsigned CH_B0  = 2;
    localparam int unsigned CH_R1  = 3;
    localparam int unsigned CH_G1  = 4;
    localparam int unsigned CH_B1  = 5;

    // LSB position of a channel's DEPTH-bit slice within the word
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned depth);
        return (NUM_CH - 1 - ch) * depth;
    endfunction

    // Width that holds max(base_delay,1) << (depth-1) without overflow
    function automatic int unsigned ontime_w(input int unsigned dly_w, input int unsigned depth);
        return dly_w + depth - 1;
    endfunction

endpackage

// File: rtl/bcm_on_timer.sv
// BCM on-time down-counter: loads max(base_delay,1) << plane, decrements per tick.
module bcm_on_timer
    import hub75_pkg::*;
#(
    parameter int unsigned DLY_W = 11,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic [DLY_W-1:0] base_delay_i,
    input  logic [PL_W-1:0]  plane_i,
    output logic             done_c
);

    localparam int unsigned ONT_W = ontime_w(DLY_W, DEPTH);

    logic [ONT_W-1:0] cnt_q;
    logic [ONT_W-1:0] cnt_d;
    logic [DLY_W-1:0] base_c;

    // Load has priority; otherwise count down one per tick until empty
    always_comb begin
        cnt_d  = cnt_q;
        base_c = (base_delay_i == '0) ? DLY_W'(1) : base_delay_i;
        if (load_i) begin
            cnt_d = ONT_W'(base_c) << plane_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last display tick is the one seen with a count of one
    assign done_c = (cnt_q == ONT_W'(1));

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 scan engine: fetch, shift, latch and BCM-display one bit-plane per pass.
module hub75_bcm_scanner
    import hub75_pkg::*;
#(
    parameter int unsigned ROW_BITS = 5,
    parameter int unsigned COL_BITS = 6,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CLK_DIV  = 3,
    parameter int unsigned DLY_W    = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [DLY_W-1:0]             base_delay,
    output logic [ROW_BITS+COL_BITS-1:0] rd_addr,
    input  logic [6*DEPTH-1:0]           rd_data,
    output logic                         LP_CLK,
    output logic                         LATCH,
    output logic                         NOE,
    output logic [ROW_BITS-1:0]          ROW,
    output logic [2:0]                   RGB0,
    output logic [2:0]                   RGB1,
    output logic                         frame_done
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW    = ROW_BITS + COL_BITS;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q;
    logic                tick_c;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [PL_W-1:0]     plane_q, plane_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [2:0]          rgb0_q, rgb0_d, rgb1_q, rgb1_d;
    logic [ROW_BITS-1:0] row_out_q, row_out_d;
    logic                frame_done_q, frame_done_d;
    logic                lp_clk_q, latch_q, noe_q;
    logic                timer_done_c;
    logic [DEPTH-1:0]    chan_c [NUM_CH];
    logic [2:0]          pix0_c, pix1_c;

    // Free-running tick divider
    assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= tick_c ? '0 : div_q + DIV_W'(1);
        end
    end

    // Split the fetched word into per-channel slices
    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        assign chan_c[g] = rd_data[ch_lsb(g, DEPTH) +: DEPTH];
    end

    // Current bit-plane of each half
    assign pix0_c = {chan_c[CH_R0][plane_q], chan_c[CH_G0][plane_q], chan_c[CH_B0][plane_q]};
    assign pix1_c = {chan_c[CH_R1][plane_q], chan_c[CH_G1][plane_q], chan_c[CH_B1][plane_q]};

    bcm_on_timer #(
        .DLY_W (DLY_W),
        .DEPTH (DEPTH),
        .PL_W  (PL_W)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .tick_i       (tick_c),
        .load_i       (tick_c && (state_q == ST_LATCH)),
        .base_delay_i (base_delay),
        .plane_i      (plane_q),
        .done_c       (timer_done_c)
    );

    // Next-state and output decode; everything advances on ticks only
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        plane_d      = plane_q;
        addr_d       = addr_q;
        rgb0_d       = rgb0_q;
        rgb1_d       = rgb1_q;
        row_out_d    = row_out_q;
        frame_done_d = 1'b0;
        if (tick_c) begin
            unique case (state_q)
                ST_IDLE: begin
                    // plane/row keep their values so a paused scan resumes in place
                    if (en) begin
                        state_d = ST_FETCH;
                        col_d   = '0;
                        addr_d  = {row_q, COL_BITS'(0)};
                    end
                end
                ST_FETCH: begin
                    state_d = ST_SHIFT_LO;
                    rgb0_d  = pix0_c;
                    rgb1_d  = pix1_c;
                end
                ST_SHIFT_LO: begin
                    // next column address goes out as LP_CLK rises; data lands within the high phase
                    state_d = ST_SHIFT_HI;
                    if (col_q != '1) begin
                        addr_d = {row_q, col_q + COL_BITS'(1)};
                    end
                end
                ST_SHIFT_HI: begin
                    if (col_q == '1) begin
                        state_d   = ST_LATCH;
                        row_out_d = row_q;
                    end else begin
                        state_d = ST_SHIFT_LO;
                        col_d   = col_q + COL_BITS'(1);
                        rgb0_d  = pix0_c;
                        rgb1_d  = pix1_c;
                    end
                end
                ST_LATCH: begin
                    state_d = ST_DISPLAY;
                end
                ST_DISPLAY: begin
                    if (timer_done_c) begin
                        state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    col_d = '0;
                    if (plane_q != PL_W'(DEPTH - 1)) begin
                        plane_d = plane_q + PL_W'(1);
                    end else begin
                        plane_d      = '0;
                        row_d        = row_q + ROW_BITS'(1);
                        frame_done_d = (row_q == '1);
                    end
                    if (en) begin
                        state_d = ST_FETCH;
                        addr_d  = {row_d, COL_BITS'(0)};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counters and registered panel outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            addr_q       <= '0;
            rgb0_q       <= '0;
            rgb1_q       <= '0;
            row_out_q    <= '0;
            frame_done_q <= 1'b0;
            lp_clk_q     <= 1'b0;
            latch_q      <= 1'b0;
            noe_q        <= 1'b1;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            addr_q       <= addr_d;
            rgb0_q       <= rgb0_d;
            rgb1_q       <= rgb1_d;
            row_out_q    <= row_out_d;
            frame_done_q <= frame_done_d;
            lp_clk_q     <= (state_d == ST_SHIFT_HI);
            latch_q      <= (state_d == ST_LATCH);
            noe_q        <= (state_d != ST_DISPLAY);
        end
    end

    assign rd_addr    = addr_q;
    assign LP_CLK     = lp_clk_q;
    assign LATCH      = latch_q;
    assign NOE        = noe_q;
    assign ROW        = row_out_q;
    assign RGB0       = rgb0_q;
    assign RGB1       = rgb1_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Directed bench for hub75_bcm_scanner on a 4x4 panel with two bit-planes.
module tb_hub75_bcm_scanner;

    localparam int unsigned ROW_BITS = 1;
    localparam int unsigned COL_BITS = 2;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned CLK_DIV  = 2;
    localparam int unsigned DLY_W    = 11;
    localparam int unsigned AW       = ROW_BITS + COL_BITS;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [DLY_W-1:0]     base_delay;
    logic [AW-1:0]        rd_addr;
    logic [6*DEPTH-1:0]   rd_data = '0;
    logic                 lp_clk;
    logic                 latch;
    logic                 noe;
    logic [ROW_BITS-1:0]  row;
    logic [2:0]           rgb0;
    logic [2:0]           rgb1;
    logic                 frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int fd_seen     = 0;

    hub75_bcm_scanner #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .DEPTH    (DEPTH),
        .CLK_DIV  (CLK_DIV),
        .DLY_W    (DLY_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .base_delay (base_delay),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .LP_CLK     (lp_clk),
        .LATCH      (latch),
        .NOE        (noe),
        .ROW        (row),
        .RGB0       (rgb0),
        .RGB1       (rgb1),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Frame-buffer content: 0xA5A pattern mixed with the address
    function automatic logic [11:0] pix(input logic [2:0] a);
        return 12'hA5A ^ {a, a, a, a};
    endfunction

    // Frame buffer with one clock of read latency
    always @(posedge clk) rd_data <= pix(rd_addr);

    // Expected {R,G,B} bit p for the upper (half=0) or lower (half=1) pixel
    function automatic logic [2:0] exp_rgb(input logic [11:0] w, input int p, input int half);
        logic [2:0] r;
        for (int k = 0; k < 3; k++) r[2-k] = w[(5 - (half*3 + k))*2 + p];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) fd_seen++;
    endtask

    // Follow one plane pass: shift data, latch, NOE-low width (in clocks)
    task automatic check_plane(input int r, input int p, input int on_ticks, input int drop_at);
        int n, g, lw, nw;
        logic prev;
        logic [11:0] w;
        n = 0;
        g = 0;
        while (latch !== 1'b1 && g < 300) begin
            prev = lp_clk;
            clk1();
            g++;
            if (prev === 1'b0 && lp_clk === 1'b1) begin
                w = pix(3'(r*4 + n));
                chk($sformatf("rgb0 r%0d p%0d c%0d", r, p, n), 32'(rgb0), 32'(exp_rgb(w, p, 0)));
                chk($sformatf("rgb1 r%0d p%0d c%0d", r, p, n), 32'(rgb1), 32'(exp_rgb(w, p, 1)));
                chk("noe_during_shift", 32'(noe), 32'd1);
                n++;
                if (n == drop_at) en = 1'b0;
            end
        end
        chk("latch_timeout", 32'(g < 300), 32'd1);
        chk($sformatf("lp_edges r%0d p%0d", r, p), 32'(n), 32'd4);
        chk($sformatf("row_at_latch r%0d p%0d", r, p), 32'(row), 32'(r));
        chk("noe_during_latch", 32'(noe), 32'd1);
        lw = 0;
        while (latch === 1'b1 && lw < 50) begin
            lw++;
            clk1();
        end
        chk("latch_width_clks", 32'(lw), 32'(CLK_DIV));
        g = 0;
        while (noe === 1'b1 && g < 50) begin
            g++;
            clk1();
        end
        nw = 0;
        while (noe === 1'b0 && nw < 500) begin
            nw++;
            clk1();
        end
        chk($sformatf("noe_low_clks r%0d p%0d", r, p), 32'(nw), 32'(on_ticks * CLK_DIV));
    endtask

    initial begin
        int lp_rises, noe_low, g;
        logic prev;
        rst        = 1'b1;
        en         = 1'b0;
        base_delay = DLY_W'(3);
        repeat (3) clk1();
        rst = 1'b0;

        // reset state
        chk("rst_noe",     32'(noe),        32'd1);
        chk("rst_lp_clk",  32'(lp_clk),     32'd0);
        chk("rst_latch",   32'(latch),      32'd0);
        chk("rst_row",     32'(row),        32'd0);
        chk("rst_rgb0",    32'(rgb0),       32'd0);
        chk("rst_rgb1",    32'(rgb1),       32'd0);
        chk("rst_rd_addr", 32'(rd_addr),    32'd0);
        chk("rst_fd",      32'(frame_done), 32'd0);

        // idle with en low: panel dark, no shifting
        lp_rises = 0;
        noe_low  = 0;
        repeat (10) begin
            prev = lp_clk;
            clk1();
            if (!prev && lp_clk) lp_rises++;
            if (noe !== 1'b1) noe_low++;
        end
        chk("idle_lp_rises", 32'(lp_rises), 32'd0);
        chk("idle_noe_low",  32'(noe_low),  32'd0);

        // full frame, base_delay=3: 3 then 6 ticks, rows 0,0,1,1
        en = 1'b1;
        check_plane(0, 0, 3, -1);
        check_plane(0, 1, 6, -1);
        check_plane(1, 0, 3, -1);
        chk("fd_before_last", 32'(fd_seen), 32'd0);
        check_plane(1, 1, 6, -1);
        repeat (4) clk1();
        chk("fd_after_frame1", 32'(fd_seen), 32'd1);

        // base_delay=0 behaves as 1: 1 then 2 ticks
        base_delay = '0;
        check_plane(0, 0, 1, -1);
        check_plane(0, 1, 2, -1);

        // en dropped mid-shift of plane 0: plane completes, then idle
        check_plane(1, 0, 1, 2);
        lp_rises = 0;
        noe_low  = 0;
        repeat (20) begin
            prev = lp_clk;
            clk1();
            if (!prev && lp_clk) lp_rises++;
            if (noe !== 1'b1) noe_low++;
        end
        chk("paused_lp_rises", 32'(lp_rises), 32'd0);
        chk("paused_noe_low",  32'(noe_low),  32'd0);
        chk("paused_fd",       32'(fd_seen),  32'd1);

        // resume at plane 1 of row 1
        en = 1'b1;
        check_plane(1, 1, 2, -1);
        repeat (4) clk1();
        chk("fd_after_frame2", 32'(fd_seen), 32'd2);

        // reset during row 1 display
        base_delay = DLY_W'(3);
        check_plane(0, 0, 3, -1);
        check_plane(0, 1, 6, -1);
        g = 0;
        while (noe === 1'b1 && g < 300) begin
            g++;
            clk1();
        end
        chk("display_timeout", 32'(g < 300), 32'd1);
        chk("row_before_rst",  32'(row),     32'd1);
        repeat (3) clk1();
        rst = 1'b1;
        clk1();
        chk("mid_rst_noe",     32'(noe),     32'd1);
        chk("mid_rst_row",     32'(row),     32'd0);
        chk("mid_rst_latch",   32'(latch),   32'd0);
        chk("mid_rst_lp_clk",  32'(lp_clk),  32'd0);
        chk("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("mid_rst_rgb0",    32'(rgb0),    32'd0);
        rst = 1'b0;
        en  = 1'b0;
        noe_low = 0;
        repeat (10) begin
            clk1();
            if (noe !== 1'b1) noe_low++;
        end
        chk("post_rst_idle_noe", 32'(noe_low), 32'd0);

        // scan restarts from row 0, plane 0
        en = 1'b1;
        check_plane(0, 0, 3, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
